// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-image loader.
// Takes a byte stream (length byte N, then 4*N little-endian data bytes),
// writes the assembled 32-bit words to consecutive instruction-memory
// addresses from 0 and holds the CPU until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte, a CSUM state and a sticky ERR state driving `err`.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_FIN  = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;       // byte lane within the current word
  logic [7:0]          left_q, left_d;       // words still to receive
  logic [ADDR_W-1:0]   widx_q, widx_d;       // next word address (wraps)
  logic [23:0]         buf_q, buf_d;         // lanes 0..2 of the word in flight
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;         // running XOR of data bytes
`endif

  // Next-state and registered-output computation; reload overrides everything.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    left_d      = left_q;
    widx_d      = widx_q;
    buf_d       = buf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    accept      = in_valid && in_ready_q;

    if (reload) begin
      // Partial words are simply dropped: buf_q is never written out.
      state_d    = S_LEN;
      lane_d     = 2'd0;
      widx_d     = '0;
      err_d      = 1'b0;
      cpu_hold_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      xor_d      = 8'h00;
`endif
    end else begin
      case (state_q)
        S_LEN: begin
          if (accept) begin
            left_d = in_data;
            if (in_data == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d    = S_CSUM;
`else
              state_d    = S_DONE;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
`endif
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            lane_d = lane_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_d  = xor_q ^ in_data;
`endif
            if (lane_q == 2'd3) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = widx_q;
              mem_wdata_d = {in_data, buf_q};
              widx_d      = widx_q + ADDR_ONE;
              left_d      = left_q - 8'd1;
              if (left_q == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = S_CSUM;
`else
                state_d = S_FIN;
`endif
              end
            end else begin
              buf_d = {in_data, buf_q[23:8]};
            end
          end
        end
        // The last write is on the bus this cycle; release the CPU after it.
        S_FIN: begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (in_data == xor_q) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end

    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LEN;
      lane_q      <= 2'd0;
      left_q      <= 8'd0;
      widx_q      <= '0;
      buf_q       <= 24'd0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      left_q      <= left_d;
      widx_q      <= widx_d;
      buf_q       <= buf_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
